byte_serializer: RTL and testbench

Parallel-to-serial transmitter. It accepts 8-bit words on a valid/ready handshake and shifts each one out one bit per accepted serial beat, with a last-bit marker. A one-word holding buffer lets back-to-back words stream with no idle beat between them. It is the transmit-side counterpart to the byte-wide enabled register stages in the datapath: those capture a word under enable; this block drains a word under handshake.

---
 rtl/byte_serializer.sv | 127 ++++++++++++
 tb/tb_byte_serializer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/byte_serializer.sv
// byte_serializer: parallel-to-serial transmitter.
// Accepts WIDTH-bit words on a valid/ready handshake and shifts each one out
// one bit per serial beat, flagging the final bit of every word. A one-word
// holding buffer lets consecutive words stream with no idle beat between them.
//
// Handshake semantics (both sides): a transfer happens at a rising edge where
// valid and ready are both high. A source holds valid and its data stable
// until that edge, and ready never depends on valid in the same cycle.
// Here in_ready is ~hold_full and ser_valid is a flop, so neither in_valid
// nor ser_ready reaches any output combinationally.
module byte_serializer #(
    parameter int WIDTH     = 8,    // word width, at least 2
    parameter bit MSB_FIRST = 1'b1  // 1: bit WIDTH-1 leaves first; 0: bit 0 leaves first
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active low
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    input  logic             ser_ready,
    output logic             busy,
    output logic             state_dbg   // 0 = IDLE, 1 = SHIFT
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] sr, sr_d;
    logic [WIDTH-1:0] hold, hold_d;
    logic             hold_full, hold_full_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic             in_xfer, beat, word_end;
    logic             ser_valid_d, ser_out_d, ser_last_d;

    assign in_ready  = ~hold_full;
    assign busy      = (state == SHIFT) | hold_full;
    assign state_dbg = (state == SHIFT);

    assign in_xfer  = in_valid & ~hold_full;
    assign beat     = (state == SHIFT) & ser_ready;
    assign word_end = beat & (cnt == CNT_LAST);

    // Next-state logic: load, shift, reload from hold or the input port at
    // word end, and park an early-arriving word in the holding buffer.
    always_comb begin
        state_d     = state;
        sr_d        = sr;
        cnt_d       = cnt;
        hold_d      = hold;
        hold_full_d = hold_full;
        if (state == IDLE) begin
            if (in_xfer) begin
                sr_d    = in;
                cnt_d   = '0;
                state_d = SHIFT;
            end
        end else if (word_end) begin
            if (hold_full) begin
                sr_d        = hold;
                hold_full_d = 1'b0;
                cnt_d       = '0;
            end else if (in_xfer) begin
                sr_d  = in;
                cnt_d = '0;
            end else begin
                state_d = IDLE;
            end
        end else begin
            if (beat) begin
                if (MSB_FIRST) begin
                    sr_d = {sr[WIDTH-2:0], 1'b0};
                end else begin
                    sr_d = {1'b0, sr[WIDTH-1:1]};
                end
                cnt_d = cnt + CW'(1);
            end
            if (in_xfer) begin
                hold_d      = in;
                hold_full_d = 1'b1;
            end
        end
    end

    // Serial outputs are computed from the next state so they can be flopped.
    always_comb begin
        ser_valid_d = (state_d == SHIFT);
        ser_out_d   = 1'b0;
        ser_last_d  = 1'b0;
        if (ser_valid_d) begin
            ser_out_d  = MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0];
            ser_last_d = (cnt_d == CNT_LAST);
        end
    end

    // State, datapath and registered serial outputs; reset aborts everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            ser_valid <= 1'b0;
            ser_out   <= 1'b0;
            ser_last  <= 1'b0;
        end else begin
            state     <= state_d;
            sr        <= sr_d;
            cnt       <= cnt_d;
            hold      <= hold_d;
            hold_full <= hold_full_d;
            ser_valid <= ser_valid_d;
            ser_out   <= ser_out_d;
            ser_last  <= ser_last_d;
        end
    end

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: per-cycle vector table plus hand-written
// sequences for stall, hold-buffer, LSB-first and mid-word reset cases.
module tb_byte_serializer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // MSB-first instance
    logic [7:0] in_d = 8'h00;
    logic       in_valid = 1'b0, ser_ready = 1'b0;
    logic       in_ready, ser_out, ser_valid, ser_last, busy, state_dbg;

    // LSB-first instance
    logic [7:0] in_l = 8'h00;
    logic       in_valid_l = 1'b0, ser_ready_l = 1'b0;
    logic       in_ready_l, ser_out_l, ser_valid_l, ser_last_l, busy_l, state_dbg_l;

    byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .in(in_d), .in_valid(in_valid), .in_ready(in_ready),
        .ser_out(ser_out), .ser_valid(ser_valid), .ser_last(ser_last),
        .ser_ready(ser_ready), .busy(busy), .state_dbg(state_dbg)
    );

    byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in(in_l), .in_valid(in_valid_l), .in_ready(in_ready_l),
        .ser_out(ser_out_l), .ser_valid(ser_valid_l), .ser_last(ser_last_l),
        .ser_ready(ser_ready_l), .busy(busy_l), .state_dbg(state_dbg_l)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string name, input logic o, input logic v, input logic l,
                            input logic ir, input logic b);
        chk({name, ".ser_out"},   {7'd0, ser_out},   {7'd0, o});
        chk({name, ".ser_valid"}, {7'd0, ser_valid}, {7'd0, v});
        chk({name, ".ser_last"},  {7'd0, ser_last},  {7'd0, l});
        chk({name, ".in_ready"},  {7'd0, in_ready},  {7'd0, ir});
        chk({name, ".busy"},      {7'd0, busy},      {7'd0, b});
    endtask

    // ---------------- driver tasks ----------------
    // Apply inputs, take one rising edge, settle 1 time unit past it.
    task automatic step(input logic [7:0] d, input logic v, input logic r);
        in_d = d; in_valid = v; ser_ready = r;
        @(posedge clk); #1;
    endtask

    task automatic step_l(input logic [7:0] d, input logic v, input logic r);
        in_l = d; in_valid_l = v; ser_ready_l = r;
        @(posedge clk); #1;
    endtask

    // Drain with ser_ready high until idle; returns edges taken.
    task automatic wait_idle(input string name, input int budget, output int n);
        n = 0;
        for (int i = 0; i < budget; i++) begin
            step(8'h00, 1'b0, 1'b1);
            n++;
            if (!busy) break;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", name, budget);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [1:0] exp_q[$];   // {last, bit} per expected beat, in order
    logic       sb_on = 1'b0;
    logic [1:0] sb_exp;

    task automatic push_word(input logic [7:0] w);
        for (int j = 0; j < 8; j++) exp_q.push_back({(j == 7), w[7-j]});
    endtask

    // A beat is consumed at the next rising edge; inputs are stable here.
    always @(negedge clk) begin
        if (sb_on && rst && ser_valid && ser_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_beat: got unexpected beat {last,bit}=%b expected none", {ser_last, ser_out});
            end else begin
                sb_exp = exp_q.pop_front();
                if ({ser_last, ser_out} !== sb_exp) begin
                    bad++;
                    $display("FAIL sb_beat: got {last,bit}=%b expected %b", {ser_last, ser_out}, sb_exp);
                end
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] din;
        logic iv, rdy;
        logic eout, evalid, elast, eirdy, ebusy;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic [7:0] d, input logic iv, input logic rdy,
                                input logic o, input logic v, input logic l,
                                input logic ir, input logic b);
        vec_t t;
        t.din = d; t.iv = iv; t.rdy = rdy;
        t.eout = o; t.evalid = v; t.elast = l; t.eirdy = ir; t.ebusy = b;
        vecs.push_back(t);
    endfunction

    logic [7:0] a5_bits;
    int n;

    initial begin
        // single word A5, MSB first: 1,0,1,0,0,1,0,1
        a5_bits = 8'hA5;
        add(8'hA5, 1, 1, 1, 1, 0, 1, 1);
        for (int i = 6; i >= 1; i--) add(8'h00, 0, 1, a5_bits[i], 1, 0, 1, 1);
        add(8'h00, 0, 1, 1, 1, 1, 1, 1);
        add(8'h00, 0, 1, 0, 0, 0, 1, 0);
        // back-to-back FF then 00 via the holding buffer
        add(8'hFF, 1, 1, 1, 1, 0, 1, 1);
        add(8'h00, 1, 1, 1, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) add(8'h00, 0, 1, 1, 1, 0, 0, 1);
        add(8'h00, 0, 1, 1, 1, 1, 0, 1);
        for (int i = 0; i < 7; i++) add(8'h00, 0, 1, 0, 1, 0, 1, 1);
        add(8'h00, 0, 1, 0, 1, 1, 1, 1);
        add(8'h00, 0, 1, 0, 0, 0, 1, 0);
        // 81 then C0 offered on the word-end edge with hold empty
        add(8'h81, 1, 1, 1, 1, 0, 1, 1);
        for (int i = 0; i < 6; i++) add(8'h00, 0, 1, 0, 1, 0, 1, 1);
        add(8'h00, 0, 1, 1, 1, 1, 1, 1);
        add(8'hC0, 1, 1, 1, 1, 0, 1, 1);
        add(8'h00, 0, 1, 1, 1, 0, 1, 1);
        for (int i = 0; i < 5; i++) add(8'h00, 0, 1, 0, 1, 0, 1, 1);
        add(8'h00, 0, 1, 0, 1, 1, 1, 1);
        add(8'h00, 0, 1, 0, 0, 0, 1, 0);

        // reset values, no clock edge yet
        #3;
        chk_outs("reset", 0, 0, 0, 1, 0);
        chk("reset.state", {7'd0, state_dbg}, 8'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk_outs("post_reset", 0, 0, 0, 1, 0);

        // table-driven vectors
        foreach (vecs[i]) begin
            step(vecs[i].din, vecs[i].iv, vecs[i].rdy);
            chk_outs($sformatf("vec%0d", i), vecs[i].eout, vecs[i].evalid,
                     vecs[i].elast, vecs[i].eirdy, vecs[i].ebusy);
        end

        // stall: 3C, ser_ready low 3 cycles while cnt==2
        sb_on = 1'b1;
        push_word(8'h3C);
        step(8'h3C, 1, 1); chk_outs("stall.c0", 0, 1, 0, 1, 1);
        step(8'h00, 0, 1); chk_outs("stall.c1", 0, 1, 0, 1, 1);
        step(8'h00, 0, 1); chk_outs("stall.c2", 1, 1, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step(8'h00, 0, 0);
            chk_outs($sformatf("stall.hold%0d", i), 1, 1, 0, 1, 1);
        end
        wait_idle("stall.drain", 20, n);
        chk("stall.drain_cycles", n[7:0], 8'd6);

        // hold full: F0 stalled, 0F into hold, AA must wait
        push_word(8'hF0); push_word(8'h0F); push_word(8'hAA);
        step(8'hF0, 1, 0); chk_outs("hold.acc1", 1, 1, 0, 1, 1);
        step(8'h0F, 1, 0); chk_outs("hold.acc2", 1, 1, 0, 0, 1);
        step(8'hAA, 1, 0); chk_outs("hold.wait0", 1, 1, 0, 0, 1);
        step(8'hAA, 1, 0); chk_outs("hold.wait1", 1, 1, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            step(8'hAA, 1, 1);
            if (i < 7) chk($sformatf("hold.in_ready%0d", i), {7'd0, in_ready}, 8'd0);
        end
        chk_outs("hold.swap", 0, 1, 0, 1, 1);
        step(8'hAA, 1, 1); chk("hold.acc3.in_ready", {7'd0, in_ready}, 8'd0);
        wait_idle("hold.drain", 40, n);
        chk("hold.drain_cycles", n[7:0], 8'd15);
        chk("hold.sb_empty", exp_q.size() == 0 ? 8'd0 : 8'd1, 8'd0);
        sb_on = 1'b0;

        // LSB first, 01: 1,0,0,0,0,0,0,0
        step_l(8'h01, 1, 1);
        chk("lsb.b0", {6'd0, ser_valid_l, ser_out_l}, 8'b11);
        for (int i = 1; i < 8; i++) begin
            step_l(8'h00, 0, 1);
            chk($sformatf("lsb.b%0d", i), {5'd0, ser_last_l, ser_valid_l, ser_out_l},
                {5'd0, (i == 7), 1'b1, 1'b0});
        end
        step_l(8'h00, 0, 1);
        chk("lsb.idle", {6'd0, ser_valid_l, busy_l}, 8'd0);

        // reset mid-word: cnt==4 with hold full
        step(8'h5A, 1, 1);
        step(8'h33, 1, 1);
        for (int i = 0; i < 3; i++) step(8'h00, 0, 1);
        chk_outs("rstmid.pre", 8'h5A >> 3 & 1, 1, 0, 0, 1);
        #2; rst = 1'b0; #1;
        chk_outs("rstmid.async", 0, 0, 0, 1, 0);
        chk("rstmid.state", {7'd0, state_dbg}, 8'd0);
        @(posedge clk); @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        sb_on = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(8'h00, 0, 1);
            chk_outs($sformatf("rstmid.after%0d", i), 0, 0, 0, 1, 0);
        end
        sb_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
